// File: rtl/adc_pkg.sv
// Shared definitions for the ADC accumulation RAM capture/readout blocks.
package adc_pkg;

  localparam int ADC_ADDR_W = 12;
  localparam int ADC_DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_PRESENT = 3'd2,
`ifdef ADC_RAM_CLEAR_EN
    ST_CLEAR   = 3'd3,
`endif
    ST_DONE    = 3'd4
  } rd_state_e;

endpackage

// File: rtl/adc_rd_delay.sv
// Read-latency timer: shifts a one-bit read-issued tag through STAGES registers.
// flush_i drops any tag in flight so an aborted read never completes.
module adc_rd_delay #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  input  logic tag_i,
  output logic tag_o
);

  logic [STAGES-1:0] sr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q <= '0;
    end else if (flush_i) begin
      sr_q <= '0;
    end else begin
      sr_q[0] <= tag_i;
      for (int i = 1; i < STAGES; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign tag_o = sr_q[STAGES-1];

endmodule

// File: rtl/adc_ram_reader.sv
// Sweeps an inclusive, wrapping RAM address range and streams each word on valid/ready.
// Define ADC_RAM_CLEAR_EN to zero every word in RAM after it has been consumed.
module adc_ram_reader
  import adc_pkg::*;
#(
  parameter int ADDR_W = ADC_ADDR_W,
  parameter int DATA_W = ADC_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  rd_state_e         state_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [ADDR_W-1:0] last_q;
  logic [DATA_W-1:0] out_data_q;
  logic              busy_q;
  logic              done_q;
  logic              ram_we_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic              issue_q;
  logic              rd_ready;
  logic              at_last_d;

  assign at_last_d = (ram_addr_q == last_q);

  // issue_q marks the cycle after a new address was driven; the tag comes out
  // once the RAM data for that address is stable on ram_rd_data.
  adc_rd_delay #(
    .STAGES(RD_LAT + 1)
  ) u_rd_delay (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .flush_i(abort),
    .tag_i  (issue_q),
    .tag_o  (rd_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ram_addr_q  <= '0;
      last_q      <= '0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ram_we_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      issue_q     <= 1'b0;
    end else begin
      issue_q  <= 1'b0;
      done_q   <= 1'b0;
      ram_we_q <= 1'b0;
      if (abort && (state_q != ST_IDLE)) begin
        state_q     <= ST_IDLE;
        busy_q      <= 1'b0;
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start && !abort) begin
              last_q     <= last_addr;
              ram_addr_q <= first_addr;
              issue_q    <= 1'b1;
              busy_q     <= 1'b1;
              state_q    <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (rd_ready) begin
              out_data_q  <= ram_rd_data;
              out_valid_q <= 1'b1;
              out_last_q  <= at_last_d;
              state_q     <= ST_PRESENT;
            end
          end
          ST_PRESENT: begin
            if (out_ready) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
`ifdef ADC_RAM_CLEAR_EN
              ram_we_q    <= 1'b1;
              state_q     <= ST_CLEAR;
`else
              if (out_last_q) begin
                done_q  <= 1'b1;
                state_q <= ST_DONE;
              end else begin
                ram_addr_q <= ram_addr_q + ADDR_W'(1);
                issue_q    <= 1'b1;
                state_q    <= ST_WAIT;
              end
`endif
            end
          end
`ifdef ADC_RAM_CLEAR_EN
          ST_CLEAR: begin
            if (at_last_d) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              ram_addr_q <= ram_addr_q + ADDR_W'(1);
              issue_q    <= 1'b1;
              state_q    <= ST_WAIT;
            end
          end
`endif
          ST_DONE: begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign ram_addr    = ram_addr_q;
  assign ram_we      = ram_we_q;
  assign ram_wr_data = '0;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;

endmodule

// File: tb/tb_adc_ram_reader.sv
// Self-checking bench for adc_ram_reader: directed and randomized sweeps against a word-list model.
module tb_adc_ram_reader;

  localparam int AW     = 12;
  localparam int DW     = 32;
  localparam int RD_LAT = 1;
`ifdef ADC_RAM_CLEAR_EN
  localparam int CLR = 1;
`else
  localparam int CLR = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] first_addr = '0;
  logic [AW-1:0] last_addr = '0;
  logic          busy, done, ram_we, out_valid, out_last;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_rd_data, ram_wr_data, out_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  adc_ram_reader #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .first_addr(first_addr), .last_addr(last_addr),
    .busy(busy), .done(done), .ram_addr(ram_addr), .ram_rd_data(ram_rd_data),
    .ram_we(ram_we), .ram_wr_data(ram_wr_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM: contents are a function of address and seed; cleared words read as zero.
  logic [31:0]   seed = 32'd0;
  bit            wiped [4096];
  logic [31:0]   rd_pipe [RD_LAT];
  logic [AW-1:0] we_addr_q [$];
  logic [DW-1:0] we_dat_q [$];

  function automatic logic [31:0] pat(input int a, input logic [31:0] s);
    return (s == 32'd0) ? 32'(10 * a) : ((32'(a) * 32'h9E3779B1) ^ s);
  endfunction

  always @(posedge clk) begin
    rd_pipe[0] <= wiped[ram_addr] ? 32'd0 : pat(int'(ram_addr), seed);
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (ram_we) begin
      wiped[ram_addr] <= 1'b1;
      we_addr_q.push_back(ram_addr);
      we_dat_q.push_back(ram_wr_data);
    end
  end
  assign ram_rd_data = rd_pipe[RD_LAT-1];

  // Reference model: what software expects to find in each word.
  bit zeroed [4096];
  function automatic logic [31:0] exp_word(input int a);
    return zeroed[a] ? 32'd0 : pat(a, seed);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: ready high, 1: ready low 5 cycles on the second beat, 2: random ready
  task automatic sweep(input int f, input int l, input int mode, input string nm);
    int n, got, stall, dcnt, t0, rise_prev, hs_cyc, wbase, budget, nw;
    logic [31:0] exp_q [$];
    logic        held, hl;
    logic [31:0] hd;
    n = ((l - f) & 4095) + 1;
    for (int i = 0; i < n; i++) exp_q.push_back(exp_word((f + i) & 4095));
    wbase = we_addr_q.size();
    first_addr = AW'(f);
    last_addr = AW'(l);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    first_addr = AW'($urandom);
    last_addr = AW'($urandom);
    check({nm, "_busy_start"}, busy, 1);
    check({nm, "_addr_first"}, ram_addr, f & 4095);
    got = 0; stall = 0; dcnt = 0; held = 0; hl = 0; hd = 0;
    rise_prev = 0; hs_cyc = -100;
    budget = n * 24 + 40;
    for (int c = 0; c < budget && dcnt == 0; c++) begin
      if (c > 0) @(negedge clk);
      start = (c == 3);
      case (mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = 1'b1;
          if (out_valid && got == 1 && stall < 5) begin
            out_ready = 1'b0;
            stall++;
          end
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      check({nm, "_busy_during"}, busy, 1);
      if (held) begin
        check({nm, "_hold_valid"}, out_valid, 1);
        check({nm, "_hold_data"}, out_data, hd);
        check({nm, "_hold_last"}, out_last, hl);
      end
      if (out_valid) begin
        if (!held) begin
          if (got == 0) check({nm, "_first_latency"}, cyc - (t0 + 1), RD_LAT + 2);
          else if (mode == 0) check({nm, "_period"}, cyc - rise_prev, RD_LAT + 3 + CLR);
          rise_prev = cyc;
        end
        if (got < n) begin
          check({nm, "_data"}, out_data, exp_q[got]);
          check({nm, "_last"}, out_last, (got == n - 1));
        end else begin
          check({nm, "_extra_beat"}, got, n - 1);
        end
        if (out_ready) begin
          check({nm, "_hs_addr"}, ram_addr, (f + got) & 4095);
          got++;
          hs_cyc = cyc + 1;
          held = 1'b0;
        end else begin
          held = 1'b1;
          hd = out_data;
          hl = out_last;
        end
      end else begin
        check({nm, "_last_idle"}, out_last, 0);
        held = 1'b0;
      end
      if (done) begin
        dcnt++;
        check({nm, "_done_after_all"}, got, n);
        check({nm, "_done_time"}, cyc, hs_cyc + CLR);
      end
    end
    start = 1'b0;
    if (dcnt == 0) check({nm, "_done_timeout"}, 0, 1);
    @(negedge clk);
    check({nm, "_busy_end"}, busy, 0);
    check({nm, "_done_one_cycle"}, done, 0);
    check({nm, "_beats"}, got, n);
    nw = we_addr_q.size() - wbase;
`ifdef ADC_RAM_CLEAR_EN
    check({nm, "_we_count"}, nw, n);
    for (int i = 0; i < n && i < nw; i++) begin
      check({nm, "_we_addr"}, we_addr_q[wbase + i], (f + i) & 4095);
      check({nm, "_we_data"}, we_dat_q[wbase + i], 0);
    end
    for (int i = 0; i < n; i++) zeroed[(f + i) & 4095] = 1'b1;
`else
    check({nm, "_no_we"}, nw, 0);
`endif
  endtask

  initial begin
    int f, len, got, bad, nwa;
    bit found;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_we", ram_we, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_data", out_data, 0);
    check("rst_wr_data", ram_wr_data, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    sweep(0, 3, 0, "basic");
    sweep(0, 3, 1, "stall");
    sweep(4094, 1, 0, "wrap");
    sweep(7, 7, 0, "single");
    sweep(5, 7, 0, "range5_7");
    check("untouched_4", wiped[4], 0);
    check("untouched_8", wiped[8], 0);
    check("wiped_6", wiped[6], CLR);

    seed = $urandom | 32'd1;
    for (int k = 0; k < 6; k++) begin
      f = $urandom_range(0, 4095);
      len = $urandom_range(1, 40);
      sweep(f, (f + len - 1) & 4095, 2, "rand");
    end
    sweep(100, 99, 0, "full");

    // abort while the second beat is presented and stalled
    seed = 32'd0;
    out_ready = 1'b1;
    first_addr = 12'd0;
    last_addr = 12'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 0;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (got == 1) begin
          found = 1'b1;
          out_ready = 1'b0;
        end else begin
          got++;
        end
      end
    end
    check("abort_reached_beat2", found, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_last", out_last, 0);
    check("abort_we", ram_we, 0);
    bad = 0;
    nwa = we_addr_q.size();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done || out_valid || busy) bad++;
    end
    check("abort_quiet", bad, 0);
    check("abort_no_late_we", we_addr_q.size() - nwa, 0);
`ifdef ADC_RAM_CLEAR_EN
    zeroed[0] = 1'b1;
`endif
    sweep(0, 3, 0, "post_abort");

    // abort and start together in IDLE: no sweep
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (busy || out_valid) bad++;
    end
    check("abort_start_ignored", bad, 0);

    // asynchronous reset in the middle of a stalled sweep
    out_ready = 1'b0;
    first_addr = 12'd2;
    last_addr = 12'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      if (out_valid) found = 1'b1;
    end
    check("rst_mid_reached", found, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_valid", out_valid, 0);
    check("arst_last", out_last, 0);
    check("arst_addr", ram_addr, 0);
    check("arst_data", out_data, 0);
    check("arst_done", done, 0);
    check("arst_we", ram_we, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (busy || out_valid || ram_addr != 12'd0) bad++;
    end
    check("post_rst_idle", bad, 0);
    sweep(2, 5, 2, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
